main_mem_arbiter: RTL
=====================

Name: main_mem_arbiter

Overview:
- Shares the single main-memory port between two requesters:
  - the instruction fetch path (`pc`-driven, read-only);
  - the RAM-instruction load/store path (`main_mem_addr` from the APU, read or write).
- Round-robin arbitration.
- One outstanding memory transaction at a time.
- Each response is routed back to the requester that issued it.
- Sits between the control unit / fetch logic and the main-memory controller.

Parameters:
- ADDR_W, 18, main-memory address width (matches APU address width).
- DATA_W, 16, memory data width (one instruction word).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request pending
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address
- if_resp_valid  out  1  fetch data valid pulse
- if_rdata  out  DATA_W  fetch data
- ls_req_valid  in  1  load/store request pending
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_addr  in  ADDR_W  load/store address
- ls_we  in  1  1 = write, 0 = read
- ls_wdata  in  DATA_W  write data
- ls_resp_valid  out  1  load/store completion pulse (read data or write ack)
- ls_rdata  out  DATA_W  read data (0 on write ack)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_resp_valid  in  1  memory response pulse (reads and writes)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state = IDLE, last_grant = LS;
  - all valid/ready outputs 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `ls_rdata` = 0;
  - `mem_we` = 0.
- Reset asserted mid-transaction abandons it. No response is ever delivered for that transaction.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - Grant is combinational from the valids and last_grant.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins. After reset IF wins the first tie.
  - Winner's `*_req_ready` = 1 for this cycle only. Ready is never asserted outside IDLE.
  - On acceptance: latch addr/we/wdata into the mem_* registers (IF always sets we = 0), record owner, set last_grant = owner, go to ISSUE.
- ISSUE:
  - `mem_req_valid` = 1 with stable fields until `mem_req_ready` is sampled high.
  - Then go to WAIT_RESP.
- WAIT_RESP:
  - `mem_req_valid` = 0.
  - On `mem_resp_valid`: register `mem_rdata` into the owner's rdata (LS write stores 0), pulse the owner's `*_resp_valid` for exactly one cycle in the following cycle, and return to IDLE in that same following cycle.
  - A new acceptance may occur in the same cycle as the resp pulse.
- `mem_resp_valid` seen outside WAIT_RESP is ignored.
- Requester rules:
  - Hold valid and fields stable until ready.
  - valid may drop only after ready.
  - The arbiter does not buffer un-accepted requests.
- Latency with a zero-wait memory (ready same cycle, response next cycle):
  - accept at cycle t, `mem_req_valid` at t+1, `mem_resp_valid` at t+2, `*_resp_valid` at t+3.
  - Back-to-back throughput: one transaction per 3 cycles.
- rdata outputs hold their last value until the next response for that requester.
- No combinational path from any mem_* input to any requester output.

Test Plan:
- Reset low mid-ISSUE -> all outputs 0 immediately; after release `busy` = 0, no resp pulse, next tie grants IF.
- Only `if_req_valid`, `if_addr` = 18'h00007; memory ready same cycle, response `mem_rdata` = 16'hC040 one cycle later -> `if_req_ready` at t, `mem_addr` = 7 with `mem_we` = 0 at t+1, `if_resp_valid` = 1 with `if_rdata` = 16'hC040 at t+3 only.
- `ls_we` = 1, `ls_addr` = 18'h00004, `ls_wdata` = 16'hBEEF, `mem_req_ready` held low 4 cycles -> `mem_req_valid` high 5 cycles with stable fields; `ls_resp_valid` = 1 with `ls_rdata` = 0 after the response; `if_resp_valid` stays 0.
- Both valid continuously for 4 transactions from reset -> grant order IF, LS, IF, LS; each resp is routed to the matching requester only.
- Spurious `mem_resp_valid` in IDLE, plus a second `mem_resp_valid` during a resp pulse -> no extra `*_resp_valid`, state unaffected.
- `if_req_valid` rises in the cycle `ls_resp_valid` pulses -> `if_req_ready` is asserted in that same cycle.

Source files
------------

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between instruction fetch
// and load/store, with one outstanding transaction and per-requester responses.
module main_mem_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_we,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t state;
    owner_t owner;
    owner_t last_grant;
    logic   if_win;
    logic   ls_win;

    // NOTE: the grant is combinational, so it is gated by reset as well as the
    // state; otherwise a held valid would see ready while reset is asserted.
    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (reset && state == IDLE) begin
            if (if_req_valid && (!ls_req_valid || last_grant == OWN_LS))
                if_win = 1'b1;
            else if (ls_req_valid)
                ls_win = 1'b1;
        end
    end

    assign if_req_ready = if_win;
    assign ls_req_ready = ls_win;
    assign busy         = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            last_grant    <= OWN_LS;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            if_rdata      <= '0;
            ls_rdata      <= '0;
        end else begin
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_win) begin
                        mem_addr      <= if_addr;
                        mem_we        <= 1'b0;
                        mem_wdata     <= '0;
                        owner         <= OWN_IF;
                        last_grant    <= OWN_IF;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end else if (ls_win) begin
                        mem_addr      <= ls_addr;
                        mem_we        <= ls_we;
                        mem_wdata     <= ls_wdata;
                        owner         <= OWN_LS;
                        last_grant    <= OWN_LS;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A write completion returns zero data to the load/store side.
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        if (owner == OWN_IF) begin
                            if_rdata      <= mem_rdata;
                            if_resp_valid <= 1'b1;
                        end else begin
                            ls_rdata      <= mem_we ? '0 : mem_rdata;
                            ls_resp_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
